pipelined_decode_stage: RTL and testbench
=========================================

// Module: pipelined_decode_stage
// PURPOSE
//  Registered ID-stage controller: decodes opcode/func into the full control bundle and registers it into the ID/EX boundary.
//  Adds load-use hazard stall, flush bubbles, illegal-op detection and a RAS_DEPTH-entry return-address stack (CALL/RET).
//  Sits between the IF/ID register and the execute stage.
// PARAMETERS
//  OPCODE_W   4   opcode width; bits above [3:0] must be zero, else the instruction is illegal
//  FUNC_W     3   func width; bits above [2:0] must be zero, else the instruction is illegal
//  REG_W      3   register-address width
//  PC_W       16  PC / return-address width
//  RAS_DEPTH  4   return-stack entries (>=2)
// PORTS
//  clk         in   1         clock; all state on rising edge
//  reset       in   1         synchronous, active-high
//  in_valid    in   1         IF/ID holds a valid instruction
//  opcode      in   OPCODE_W  instruction opcode
//  func        in   FUNC_W    function field
//  rs1,rs2,rd  in   REG_W     source / destination registers
//  pc_plus1    in   PC_W      return address pushed on CALL
//  ex_stall    in   1         downstream hold; output register frozen
//  flush       in   1         kill: bubble into ID/EX
//  id_stall    out  1         comb.; IF/ID must hold its instruction
//  out_valid   out  1         ID/EX bundle valid
//  for_sig,update_rr,jmp,sel_pc_src,load,rtype,logical,write_reg,imm,bne,branch,write_mem  out 1 each  registered controls
//  alu_ctrl    out  3         registered ALU op
//  out_rd      out  REG_W     registered rd
//  ret_addr    out  PC_W      registered RAS top, captured on an accepted RET
//  illegal     out  1         one-cycle pulse per accepted illegal instruction
//  ras_ovf,ras_unf  out 1     sticky overflow / underflow; cleared only by reset
// BEHAVIOUR
//  Opcodes: 0000 RTYPE, 0001 JTYPE (func 000 JMP, 001 CALL, 010 RET), 0010 ANDI, 0011 ADDI, 0100 LOAD, 0101 STORE, 0110 BEQ, 0111 BNE, 1000 FOR.
//  Illegal: opcode 1001-1111, RTYPE func 101-111, JTYPE func 011-111.
//  Decode: for_sig=FOR; update_rr=FOR|CALL; jmp=JMP|CALL; sel_pc_src=JTYPE; load=LOAD; rtype=RTYPE; logical=ANDI;
//   write_reg=not(JTYPE,BEQ,BNE,STORE); imm=ADDI|ANDI|LOAD|STORE; bne=BNE; branch=BEQ|BNE; write_mem=STORE.
//  alu_ctrl: RTYPE = func (000 and, 001 add, 010 sub, 011 sll, 100 srl); ANDI 000; ADDI/LOAD/STORE 001; all others 010.
//  Hazard (comb.): id_stall = in_valid & out_valid & load & (out_rd==rs1 | (out_rd==rs2 & uses_rs2)).
//   uses_rs2 = RTYPE|STORE|BEQ|BNE.
//  accept = in_valid & ~id_stall & ~ex_stall & ~flush & ~reset.
//  Register update priority: reset > flush > ex_stall > load-use bubble > accept > idle bubble.
//   reset: every output, RAS count/pointer and sticky flags go to 0.
//   flush: out_valid and all controls 0 next cycle; the RAS is not touched; ret_addr holds.
//   ex_stall (no flush): all registered outputs hold; illegal goes 0.
//   bubble (id_stall, or no in_valid): out_valid=0, controls 0; out_rd don't-care.
//   accept of a legal instruction: bundle and out_rd registered, out_valid=1. Latency is 1 cycle.
//   accept of an illegal instruction: bubble plus illegal=1 for exactly 1 cycle.
//  Invariant: any control =1 implies out_valid=1.
//  RAS is circular, with pointer sp and count cnt (0..RAS_DEPTH); it changes only on accept.
//   CALL: push pc_plus1. If cnt==RAS_DEPTH, the oldest entry is overwritten, cnt stays saturated, and ras_ovf is set.
//   RET: ret_addr <= top; pop. If cnt==0: ret_addr <= 0, cnt stays 0, ras_unf is set.
//   JMP and FOR never touch the RAS.
//  ret_addr changes only on an accepted RET or on reset.
// TESTING
//  T1 decode sweep: each legal opcode/func, accepted back-to-back -> bundle matches the table one cycle later; ADDI gives imm=1, write_reg=1, alu_ctrl=001.
//  T2 load-use: LOAD rd=3, then ADD rs1=3 -> id_stall=1 for 1 cycle, one bubble (out_valid=0), then ADD issues; same test with rs2=3 on ADDI -> no stall.
//  T3 RAS: CALL pc_plus1=0x10, then CALL 0x20, RET, RET -> ret_addr 0x20 then 0x10; a further RET -> ret_addr 0, ras_unf=1 sticky.
//  T4 overflow: RAS_DEPTH+1 CALLs (0x1..0x5) -> ras_ovf=1; RAS_DEPTH RETs return 0x5,0x4,0x3,0x2.
//  T5 flush/ex_stall: flush during CALL -> out_valid=0 and RAS unchanged; ex_stall for 3 cycles -> outputs frozen, no instruction lost or duplicated.
//  T6 illegal/reset: opcode 1010 -> illegal pulse of 1 cycle with out_valid=0; reset mid-RAS -> all outputs and flags 0 the next cycle.

Source files
------------

// File: rtl/pipelined_decode_stage.sv
// ID-stage controller: decodes opcode/func into the control bundle and registers it
// into the ID/EX boundary. It handles load-use stalls, flush bubbles, illegal-op pulses
// and a circular return-address stack for CALL and RET.
module pipelined_decode_stage #(
    parameter int OPCODE_W  = 4,
    parameter int FUNC_W    = 3,
    parameter int REG_W     = 3,
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [REG_W-1:0]    rd,
    input  logic [PC_W-1:0]     pc_plus1,
    input  logic                ex_stall,
    input  logic                flush,
    output logic                id_stall,
    output logic                out_valid,
    output logic                for_sig,
    output logic                update_rr,
    output logic                jmp,
    output logic                sel_pc_src,
    output logic                load,
    output logic                rtype,
    output logic                logical,
    output logic                write_reg,
    output logic                imm,
    output logic                bne,
    output logic                branch,
    output logic                write_mem,
    output logic [2:0]          alu_ctrl,
    output logic [REG_W-1:0]    out_rd,
    output logic [PC_W-1:0]     ret_addr,
    output logic                illegal,
    output logic                ras_ovf,
    output logic                ras_unf
);
    localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(RAS_DEPTH - 1);

    typedef struct packed {
        logic       for_sig;
        logic       update_rr;
        logic       jmp;
        logic       sel_pc_src;
        logic       load;
        logic       rtype;
        logic       logical;
        logic       write_reg;
        logic       imm;
        logic       bne;
        logic       branch;
        logic       write_mem;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    ctrl_t           dec, ctrl_q;
    logic            legal, is_call, is_ret, uses_rs2, hi_zero, accept;
    logic            do_push, do_pop;
    logic [3:0]      op;
    logic [2:0]      fn;
    logic [SP_W-1:0] sp, sp_inc, sp_dec;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0] ras_mem [RAS_DEPTH];

    assign op      = opcode[3:0];
    assign fn      = func[2:0];
    // Wider-than-needed opcode/func fields must carry zeros in their upper bits.
    assign hi_zero = ((opcode >> 4) == '0) && ((func >> 3) == '0);

    // Instruction decode: control bundle, legality and RAS / hazard qualifiers.
    always_comb begin
        dec          = '0;
        dec.alu_ctrl = 3'b010;
        legal        = hi_zero;
        is_call      = 1'b0;
        is_ret       = 1'b0;
        uses_rs2     = 1'b0;
        case (op)
            4'd0: begin
                dec.rtype     = 1'b1;
                dec.write_reg = 1'b1;
                dec.alu_ctrl  = fn;
                uses_rs2      = 1'b1;
                if (fn > 3'd4) legal = 1'b0;
            end
            4'd1: begin
                dec.sel_pc_src = 1'b1;
                case (fn)
                    3'd0:    dec.jmp = 1'b1;
                    3'd1:    begin dec.jmp = 1'b1; dec.update_rr = 1'b1; is_call = 1'b1; end
                    3'd2:    is_ret = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            4'd2: begin dec.logical = 1'b1; dec.imm = 1'b1; dec.write_reg = 1'b1; dec.alu_ctrl = 3'b000; end
            4'd3: begin dec.imm = 1'b1; dec.write_reg = 1'b1; dec.alu_ctrl = 3'b001; end
            4'd4: begin dec.load = 1'b1; dec.imm = 1'b1; dec.write_reg = 1'b1; dec.alu_ctrl = 3'b001; end
            4'd5: begin dec.imm = 1'b1; dec.write_mem = 1'b1; dec.alu_ctrl = 3'b001; uses_rs2 = 1'b1; end
            4'd6: begin dec.branch = 1'b1; uses_rs2 = 1'b1; end
            4'd7: begin dec.branch = 1'b1; dec.bne = 1'b1; uses_rs2 = 1'b1; end
            4'd8: begin dec.for_sig = 1'b1; dec.update_rr = 1'b1; dec.write_reg = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    // A load in ID/EX whose destination is read by the instruction in ID must wait one cycle.
    assign id_stall = in_valid & out_valid & ctrl_q.load &
                      ((out_rd == rs1) | ((out_rd == rs2) & uses_rs2));
    assign accept   = in_valid & ~id_stall & ~ex_stall & ~flush & ~reset;
    assign do_push  = accept & legal & is_call;
    assign do_pop   = accept & legal & is_ret;
    assign sp_inc   = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
    assign sp_dec   = (sp == '0) ? SP_LAST : sp - SP_W'(1);

    // ID/EX register: reset > flush > ex_stall > bubble > accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (ex_stall) begin
            illegal   <= 1'b0;
        end else if (id_stall || !in_valid) begin
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (legal) begin
            ctrl_q    <= dec;
            out_valid <= 1'b1;
            out_rd    <= rd;
            illegal   <= 1'b0;
        end else begin
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b1;
        end
    end

    // RAS bookkeeping: sp is the next free slot; a full push overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp       <= '0;
            cnt      <= '0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            ret_addr <= '0;
        end else if (do_push) begin
            sp <= sp_inc;
            if (cnt == CNT_FULL) ras_ovf <= 1'b1;
            else                 cnt     <= cnt + CNT_W'(1);
        end else if (do_pop) begin
            if (cnt == '0) begin
                ret_addr <= '0;
                ras_unf  <= 1'b1;
            end else begin
                ret_addr <= ras_mem[sp_dec];
                sp       <= sp_dec;
                cnt      <= cnt - CNT_W'(1);
            end
        end
    end

    // RAS storage: contents are only meaningful below cnt, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) ras_mem[sp] <= pc_plus1;
    end

    assign for_sig    = ctrl_q.for_sig;
    assign update_rr  = ctrl_q.update_rr;
    assign jmp        = ctrl_q.jmp;
    assign sel_pc_src = ctrl_q.sel_pc_src;
    assign load       = ctrl_q.load;
    assign rtype      = ctrl_q.rtype;
    assign logical    = ctrl_q.logical;
    assign write_reg  = ctrl_q.write_reg;
    assign imm        = ctrl_q.imm;
    assign bne        = ctrl_q.bne;
    assign branch     = ctrl_q.branch;
    assign write_mem  = ctrl_q.write_mem;
    assign alu_ctrl   = ctrl_q.alu_ctrl;
endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: the expected bundle of every accepted
// instruction is queued at drive time and popped when out_valid shows it.
module tb_pipelined_decode_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, ex_stall, flush;
    logic [3:0]  opcode;
    logic [2:0]  func, rs1, rs2, rd;
    logic [15:0] pc_plus1;
    logic        id_stall, out_valid, for_sig, update_rr, jmp, sel_pc_src, load, rtype;
    logic        logical, write_reg, imm, bne, branch, write_mem, illegal, ras_ovf, ras_unf;
    logic [2:0]  alu_ctrl, out_rd;
    logic [15:0] ret_addr;

    typedef struct {
        logic [14:0] ctrl;
        logic [2:0]  rd;
        logic        chk_ret;
        logic [15:0] ret;
    } sb_t;

    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_ill = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
    logic [34:0] frozen = '0;

    pipelined_decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .func(func),
        .rs1(rs1), .rs2(rs2), .rd(rd), .pc_plus1(pc_plus1), .ex_stall(ex_stall),
        .flush(flush), .id_stall(id_stall), .out_valid(out_valid), .for_sig(for_sig),
        .update_rr(update_rr), .jmp(jmp), .sel_pc_src(sel_pc_src), .load(load),
        .rtype(rtype), .logical(logical), .write_reg(write_reg), .imm(imm), .bne(bne),
        .branch(branch), .write_mem(write_mem), .alu_ctrl(alu_ctrl), .out_rd(out_rd),
        .ret_addr(ret_addr), .illegal(illegal), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    // Expected bundle {for,update_rr,jmp,sel_pc_src,load,rtype,logical,write_reg,imm,bne,branch,write_mem,alu}
    function automatic logic [14:0] ectl(input logic [3:0] op, input logic [2:0] fn);
        case (op)
            4'd0: return {12'b000001010000, fn};
            4'd1: begin
                if (fn == 3'd0)      return {12'b001100000000, 3'b010};
                else if (fn == 3'd1) return {12'b011100000000, 3'b010};
                else                 return {12'b000100000000, 3'b010};
            end
            4'd2: return {12'b000000111000, 3'b000};
            4'd3: return {12'b000000011000, 3'b001};
            4'd4: return {12'b000010011000, 3'b001};
            4'd5: return {12'b000000001001, 3'b001};
            4'd6: return {12'b000000000010, 3'b010};
            4'd7: return {12'b000000000110, 3'b010};
            default: return {12'b110000010000, 3'b010};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; then compare the ID/EX outputs against the scoreboard or the frozen snapshot.
    task automatic tick();
        logic        was_stall;
        logic [14:0] cur;
        sb_t         e;
        was_stall = ex_stall;
        @(posedge clk);
        #1;
        cur = {for_sig, update_rr, jmp, sel_pc_src, load, rtype, logical, write_reg,
               imm, bne, branch, write_mem, alu_ctrl};
        if (was_stall) begin
            chk("frozen", {29'd0, out_valid, cur, out_rd, ret_addr}, {29'd0, frozen});
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_issue", 64'(out_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("ctrl", 64'(cur), 64'(e.ctrl));
                chk("out_rd", 64'(out_rd), 64'(e.rd));
                if (e.chk_ret) chk("ret_addr", 64'(ret_addr), 64'(e.ret));
            end
        end else begin
            chk("bubble_ctrl", 64'(cur), 64'd0);
        end
        chk("illegal", 64'(illegal), 64'(exp_ill));
        chk("ras_ovf", 64'(ras_ovf), 64'(exp_ovf));
        chk("ras_unf", 64'(ras_unf), 64'(exp_unf));
        exp_ill = 1'b0;
        frozen  = {out_valid, cur, out_rd, ret_addr};
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] fn, input logic [2:0] r1,
                         input logic [2:0] r2, input logic [2:0] d, input logic [15:0] pc);
        in_valid = 1'b1; opcode = op; func = fn; rs1 = r1; rs2 = r2; rd = d; pc_plus1 = pc;
    endtask

    task automatic push(input logic [3:0] op, input logic [2:0] fn, input logic [2:0] d,
                        input logic chk_ret, input logic [15:0] ret);
        sb_t e;
        e.ctrl = ectl(op, fn); e.rd = d; e.chk_ret = chk_ret; e.ret = ret;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] fn, input logic [2:0] d,
                         input logic [15:0] pc, input logic chk_ret, input logic [15:0] ret);
        drive(op, fn, 3'd0, 3'd0, d, pc);
        push(op, fn, d, chk_ret, ret);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        opcode = '0; func = '0; rs1 = '0; rs2 = '0; rd = '0; pc_plus1 = '0;
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_ret", 64'(ret_addr), 64'd0);
        reset = 1'b0;
        idle();

        // T1: decode sweep, back to back
        for (int f = 0; f < 5; f++) issue(4'd0, 3'(f), 3'(f), 16'h0, 1'b0, 16'h0);
        issue(4'd1, 3'd0, 3'd1, 16'h0, 1'b0, 16'h0);
        issue(4'd1, 3'd1, 3'd2, 16'h77, 1'b0, 16'h0);
        issue(4'd1, 3'd2, 3'd3, 16'h0, 1'b1, 16'h77);
        issue(4'd2, 3'd0, 3'd4, 16'h0, 1'b0, 16'h0);
        issue(4'd3, 3'd0, 3'd5, 16'h0, 1'b0, 16'h0);
        issue(4'd4, 3'd0, 3'd6, 16'h0, 1'b0, 16'h0);
        issue(4'd5, 3'd0, 3'd7, 16'h0, 1'b0, 16'h0);
        issue(4'd6, 3'd0, 3'd1, 16'h0, 1'b0, 16'h0);
        issue(4'd7, 3'd0, 3'd2, 16'h0, 1'b0, 16'h0);
        issue(4'd8, 3'd0, 3'd3, 16'h0, 1'b0, 16'h0);
        idle();

        // T2: load-use on rs1, on rs2 of an RTYPE, and none for ADDI rs2
        issue(4'd4, 3'd0, 3'd3, 16'h0, 1'b0, 16'h0);
        drive(4'd0, 3'd1, 3'd3, 3'd0, 3'd4, 16'h0);
        #1 chk("stall_rs1", 64'(id_stall), 64'd1);
        tick();
        chk("stall_clear", 64'(id_stall), 64'd0);
        push(4'd0, 3'd1, 3'd4, 1'b0, 16'h0);
        tick();
        issue(4'd4, 3'd0, 3'd3, 16'h0, 1'b0, 16'h0);
        drive(4'd0, 3'd2, 3'd0, 3'd3, 3'd5, 16'h0);
        #1 chk("stall_rs2", 64'(id_stall), 64'd1);
        tick();
        push(4'd0, 3'd2, 3'd5, 1'b0, 16'h0);
        tick();
        issue(4'd4, 3'd0, 3'd3, 16'h0, 1'b0, 16'h0);
        drive(4'd3, 3'd0, 3'd0, 3'd3, 3'd6, 16'h0);
        #1 chk("no_stall_addi", 64'(id_stall), 64'd0);
        push(4'd3, 3'd0, 3'd6, 1'b0, 16'h0);
        tick();

        // T3: nested CALL/RET then underflow
        issue(4'd1, 3'd1, 3'd0, 16'h10, 1'b0, 16'h0);
        issue(4'd1, 3'd1, 3'd0, 16'h20, 1'b0, 16'h0);
        issue(4'd1, 3'd2, 3'd0, 16'h0, 1'b1, 16'h20);
        issue(4'd1, 3'd2, 3'd0, 16'h0, 1'b1, 16'h10);
        exp_unf = 1'b1;
        issue(4'd1, 3'd2, 3'd0, 16'h0, 1'b1, 16'h0);
        idle();

        // T4: overflow drops the oldest entry
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) exp_ovf = 1'b1;
            issue(4'd1, 3'd1, 3'd0, 16'(i), 1'b0, 16'h0);
        end
        for (int i = 5; i >= 2; i--) issue(4'd1, 3'd2, 3'd0, 16'h0, 1'b1, 16'(i));

        // T5: flushed CALL leaves the RAS alone; ex_stall freezes and loses nothing
        issue(4'd1, 3'd1, 3'd0, 16'h40, 1'b0, 16'h0);
        drive(4'd1, 3'd1, 3'd0, 3'd0, 3'd0, 16'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(4'd1, 3'd2, 3'd0, 16'h0, 1'b1, 16'h40);
        issue(4'd3, 3'd0, 3'd2, 16'h0, 1'b0, 16'h0);
        drive(4'd2, 3'd0, 3'd0, 3'd0, 3'd7, 16'h0);
        ex_stall = 1'b1;
        repeat (3) tick();
        ex_stall = 1'b0;
        push(4'd2, 3'd0, 3'd7, 1'b0, 16'h0);
        tick();
        idle();

        // T6: illegal pulses, then reset with entries on the RAS
        drive(4'b1010, 3'd0, 3'd0, 3'd0, 3'd1, 16'h0);
        exp_ill = 1'b1;
        tick();
        idle();
        drive(4'd0, 3'd5, 3'd0, 3'd0, 3'd1, 16'h0);
        exp_ill = 1'b1;
        tick();
        drive(4'd1, 3'd3, 3'd0, 3'd0, 3'd1, 16'h0);
        exp_ill = 1'b1;
        tick();
        issue(4'd1, 3'd1, 3'd0, 16'h33, 1'b0, 16'h0);
        issue(4'd1, 3'd2, 3'd1, 16'h0, 1'b1, 16'h33);
        issue(4'd1, 3'd1, 3'd0, 16'h44, 1'b0, 16'h0);
        drive(4'd1, 3'd1, 3'd0, 3'd0, 3'd0, 16'h55);
        reset = 1'b1; exp_ovf = 1'b0; exp_unf = 1'b0;
        tick();
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_ret", 64'(ret_addr), 64'd0);
        chk("rst2_rd", 64'(out_rd), 64'd0);
        reset = 1'b0;
        exp_unf = 1'b1;
        issue(4'd1, 3'd2, 3'd0, 16'h0, 1'b1, 16'h0);
        idle();
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
